pwm_capture: RTL

PWM_CAPTURE -- requirements
Module: pwm_capture

---
 rtl/pwm_capture_pkg.sv | 24 ++
 rtl/pwm_capture_div.sv | 98 +++++++++
 rtl/pwm_capture.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/pwm_capture_pkg.sv
// Shared encodings and default sizes for the PWM capture block.
package pwm_capture_pkg;

  localparam int DEF_WIDTH = 12;
  localparam int DEF_CNT_W = 20;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } meas_state_t;

  typedef enum logic {
    DIV_IDLE = 1'b0,
    DIV_RUN  = 1'b1
  } div_state_t;

  // Snapshot of both state machines, exported for observation.
  typedef struct packed {
    meas_state_t meas;
    div_state_t  div;
  } dbg_t;

endpackage

// File: rtl/pwm_capture_div.sv
// Sequential restoring divider: quotient = floor(num * 2^WIDTH / den),
// one quotient bit per cycle, clamped to all-ones when num >= den.
// Handshake: start is honoured only in the cycle busy is low; done pulses
// for exactly one cycle and res_* are valid from that cycle onward.
module seq_divider
  import pwm_capture_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk_i,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] num,
  input  logic [CNT_W-1:0] den,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] res_high,
  output logic [CNT_W-1:0] res_period,
  output logic [WIDTH-1:0] res_quo,
  output div_state_t       div_state
);

  localparam int SW = $clog2(WIDTH + 1);

  div_state_t       state_q, state_d;
  logic [SW-1:0]    step_q;
  logic [CNT_W:0]   rem_q;
  logic [CNT_W:0]   trial;
  logic [CNT_W-1:0] num_q, den_q;
  logic [WIDTH-1:0] quo_q, quo_next;
  logic             clamp_q, take, last_step;

  // One restoring step: shift remainder, subtract divisor if it fits.
  always_comb begin
    trial     = {rem_q[CNT_W-1:0], 1'b0};
    take      = (trial >= {1'b0, den_q});
    quo_next  = {quo_q[WIDTH-2:0], take};
    last_step = (step_q == SW'(WIDTH - 1));
  end

  // Divider next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      DIV_IDLE: if (start) state_d = DIV_RUN;
      DIV_RUN:  if (last_step) state_d = DIV_IDLE;
      default:  state_d = DIV_IDLE;
    endcase
  end

  // Divider state register.
  always_ff @(posedge clk_i or negedge reset) begin
    if (!reset) state_q <= DIV_IDLE;
    else        state_q <= state_d;
  end

  // Operand capture, iteration and result registers.
  always_ff @(posedge clk_i or negedge reset) begin
    if (!reset) begin
      rem_q      <= '0;
      num_q      <= '0;
      den_q      <= '0;
      quo_q      <= '0;
      step_q     <= '0;
      clamp_q    <= 1'b0;
      done       <= 1'b0;
      res_high   <= '0;
      res_period <= '0;
      res_quo    <= '0;
    end else begin
      done <= 1'b0;
      if (state_q == DIV_IDLE && start) begin
        rem_q   <= {1'b0, num};
        num_q   <= num;
        den_q   <= den;
        quo_q   <= '0;
        step_q  <= '0;
        // A ratio >= 1 cannot be represented; also guards den == 0.
        clamp_q <= (num >= den);
      end else if (state_q == DIV_RUN) begin
        rem_q  <= take ? (trial - {1'b0, den_q}) : trial;
        quo_q  <= quo_next;
        step_q <= step_q + SW'(1);
        if (last_step) begin
          done       <= 1'b1;
          res_high   <= num_q;
          res_period <= den_q;
          res_quo    <= clamp_q ? '1 : quo_next;
        end
      end
    end
  end

  assign busy      = (state_q == DIV_RUN);
  assign div_state = state_q;

endmodule

// File: rtl/pwm_capture.sv
// PWM capture: synchronises pwm_i, measures high time and period between
// successive rises, and hands each completed measurement to the divider.
module pwm_capture
  import pwm_capture_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk_i,
  input  logic             reset,
  input  logic             pwm_i,
  output logic [CNT_W-1:0] high_o,
  output logic [CNT_W-1:0] period_o,
  output logic [WIDTH-1:0] duty_o,
  output logic             dataf_o,
  output logic             timeout_o,
  output logic             overrun_o,
  output dbg_t             dbg_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             sync1, sync2, sync3;
  logic             rise, fall;
  meas_state_t      state_q, state_d;
  logic [CNT_W-1:0] hi_cnt, per_cnt, hi_lat;
  logic             load_cnt, latch_hi, meas_done, to_timeout, clr_timeout;
  logic             div_start, div_busy;
  div_state_t       div_state;

  // Two-flop synchroniser plus one history flop for edge detection.
  always_ff @(posedge clk_i or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= pwm_i;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign rise = sync2 & ~sync3;
  assign fall = ~sync2 & sync3;

  // Measurement next-state and control; a completing rise beats timeout.
  always_comb begin
    state_d     = state_q;
    load_cnt    = 1'b0;
    latch_hi    = 1'b0;
    meas_done   = 1'b0;
    to_timeout  = 1'b0;
    clr_timeout = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise) begin
          load_cnt    = 1'b1;
          clr_timeout = 1'b1;
          state_d     = HIGH;
        end
      end
      HIGH: begin
        if (per_cnt == CNT_MAX) begin
          to_timeout = 1'b1;
          state_d    = IDLE;
        end else if (fall) begin
          latch_hi = 1'b1;
          state_d  = LOW;
        end
      end
      LOW: begin
        if (rise) begin
          meas_done = 1'b1;
          load_cnt  = 1'b1;
          state_d   = HIGH;
        end else if (per_cnt == CNT_MAX) begin
          to_timeout = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Measurement state register.
  always_ff @(posedge clk_i or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // High-time and period counters; a rise restarts both at 1.
  always_ff @(posedge clk_i or negedge reset) begin
    if (!reset) begin
      hi_cnt  <= '0;
      per_cnt <= '0;
    end else if (load_cnt) begin
      hi_cnt  <= CNT_W'(1);
      per_cnt <= CNT_W'(1);
    end else if (!to_timeout && state_q == HIGH) begin
      hi_cnt  <= hi_cnt + CNT_W'(1);
      per_cnt <= per_cnt + CNT_W'(1);
    end else if (!to_timeout && state_q == LOW) begin
      per_cnt <= per_cnt + CNT_W'(1);
    end
  end

  // Hold the high time from the fall until the period completes.
  always_ff @(posedge clk_i or negedge reset) begin
    if (!reset)        hi_lat <= '0;
    else if (latch_hi) hi_lat <= hi_cnt;
  end

  // Timeout level and dropped-measurement pulse.
  always_ff @(posedge clk_i or negedge reset) begin
    if (!reset) begin
      timeout_o <= 1'b1;
      overrun_o <= 1'b0;
    end else begin
      overrun_o <= meas_done & div_busy;
      if (to_timeout)       timeout_o <= 1'b1;
      else if (clr_timeout) timeout_o <= 1'b0;
    end
  end

  assign div_start = meas_done & ~div_busy;

  seq_divider #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) u_div (
    .clk_i      (clk_i),
    .reset      (reset),
    .start      (div_start),
    .num        (hi_lat),
    .den        (per_cnt),
    .busy       (div_busy),
    .done       (dataf_o),
    .res_high   (high_o),
    .res_period (period_o),
    .res_quo    (duty_o),
    .div_state  (div_state)
  );

  assign dbg_o.meas = state_q;
  assign dbg_o.div  = div_state;

endmodule
